dram_read_arbiter: RTL and testbench

//  Shares one DRAM read channel (addr/len/en in, data/valid/busy back) between NUM_REQ image-path requesters.

---
 rtl/dram_read_arbiter.sv | 129 ++++++++++++
 tb/tb_dram_read_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_read_arbiter.sv
// dram_read_arbiter: round-robin sharing of one DRAM read channel between NUM_REQ requesters,
// one queued burst per requester, one burst outstanding, beats routed back to the burst owner.
module dram_read_arbiter #(
    parameter int NUM_REQ         = 2,
    parameter int DRAM_ADDR_WIDTH = 39,
    parameter int DRAM_DATA_WIDTH = 128
) (
    input  logic                               clk_pixel,
    input  logic                               dram_arb_resetn,
    input  logic [NUM_REQ*DRAM_ADDR_WIDTH-1:0] req_read_addr,
    input  logic [NUM_REQ*8-1:0]               req_read_len,
    input  logic [NUM_REQ-1:0]                 req_read_en,
    output logic [NUM_REQ-1:0]                 req_busy,
    output logic [NUM_REQ-1:0]                 req_drop,
    output logic [DRAM_DATA_WIDTH-1:0]         req_read_data,
    output logic [NUM_REQ-1:0]                 req_read_valid,
    output logic [DRAM_ADDR_WIDTH-1:0]         mem_read_addr,
    output logic [7:0]                         mem_read_len,
    output logic                               mem_read_en,
    input  logic [DRAM_DATA_WIDTH-1:0]         mem_read_data,
    input  logic                               mem_read_valid,
    input  logic                               mem_read_busy,
    output logic                               stray_beat
);
    localparam int PW = $clog2(NUM_REQ);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] ACK   = 2'd2;
    localparam logic [1:0] DATA  = 2'd3;

    logic [1:0]                 state;
    logic [NUM_REQ-1:0]         slot_v, accept, owner_oh, clr;
    logic [DRAM_ADDR_WIDTH-1:0] s_addr [NUM_REQ];
    logic [7:0]                 s_len  [NUM_REQ];
    logic [PW-1:0]              ptr, owner, gnt, nxt_ptr;
    logic [7:0]                 cnt;
    logic                       found, in_burst, beat, last;

    always_comb begin
        for (int k = 0; k < NUM_REQ; k++)
            accept[k] = req_read_en[k] && !slot_v[k] && (req_read_len[k*8 +: 8] != 8'd0);
    end

    // First pending slot at or after the round-robin pointer, wrapping.
    always_comb begin : rr
        int j;
        logic [PW-1:0] idx;
        j     = 0;
        idx   = '0;
        gnt   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            idx = PW'(j);
            if (!found && slot_v[idx]) begin
                found = 1'b1;
                gnt   = idx;
            end
        end
    end

    assign in_burst    = (state == ACK) || (state == DATA);
    assign beat        = in_burst && mem_read_valid;
    assign last        = beat && (cnt + 8'd1 == s_len[owner]);
    assign owner_oh    = NUM_REQ'(1) << owner;
    assign clr         = last ? owner_oh : '0;
    assign nxt_ptr     = (owner == PW'(NUM_REQ - 1)) ? '0 : owner + PW'(1);
    assign mem_read_en = (state == ISSUE);
    assign req_busy    = slot_v;

    always_ff @(posedge clk_pixel or negedge dram_arb_resetn) begin
        if (!dram_arb_resetn) begin
            slot_v   <= '0;
            req_drop <= '0;
            for (int k = 0; k < NUM_REQ; k++) begin
                s_addr[k] <= '0;
                s_len[k]  <= '0;
            end
        end else begin
            slot_v   <= (slot_v & ~clr) | accept;
            req_drop <= req_read_en & ~accept;
            for (int k = 0; k < NUM_REQ; k++) begin
                if (accept[k]) begin
                    s_addr[k] <= req_read_addr[k*DRAM_ADDR_WIDTH +: DRAM_ADDR_WIDTH];
                    s_len[k]  <= req_read_len[k*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_pixel or negedge dram_arb_resetn) begin
        if (!dram_arb_resetn) begin
            state          <= IDLE;
            ptr            <= '0;
            owner          <= '0;
            cnt            <= '0;
            mem_read_addr  <= '0;
            mem_read_len   <= '0;
            req_read_data  <= '0;
            req_read_valid <= '0;
            stray_beat     <= 1'b0;
        end else begin
            req_read_valid <= beat ? owner_oh : '0;
            stray_beat     <= mem_read_valid && !in_burst;
            if (state == IDLE && found && !mem_read_busy) begin
                owner         <= gnt;
                mem_read_addr <= s_addr[gnt];
                mem_read_len  <= s_len[gnt];
                state         <= ISSUE;
            end
            if (state == ISSUE) begin
                cnt   <= '0;
                state <= ACK;
            end
            if (state == ACK && (mem_read_busy || mem_read_valid))
                state <= DATA;
            // A beat in ACK is already part of the burst; a final beat overrides the ACK->DATA move.
            if (beat) begin
                req_read_data <= mem_read_data;
                cnt           <= cnt + 8'd1;
            end
            if (last) begin
                ptr   <= nxt_ptr;
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_dram_read_arbiter.sv
// tb_dram_read_arbiter: directed stimulus with scoreboard queues for issued bursts and returned beats.
module tb_dram_read_arbiter;
    logic         clk;
    logic         dram_arb_resetn;
    logic [77:0]  req_read_addr;
    logic [15:0]  req_read_len;
    logic [1:0]   req_read_en;
    logic [1:0]   req_busy, req_drop, req_read_valid;
    logic [127:0] req_read_data, mem_read_data;
    logic [38:0]  mem_read_addr;
    logic [7:0]   mem_read_len;
    logic         mem_read_en, mem_read_valid, mem_read_busy, stray_beat;

    int total = 0;
    int bad   = 0;
    int stray_cnt = 0;
    logic [46:0]  exp_iss  [$];
    logic [129:0] exp_beat [$];

    dram_read_arbiter #(.NUM_REQ(2), .DRAM_ADDR_WIDTH(39), .DRAM_DATA_WIDTH(128)) dut (
        .clk_pixel(clk), .dram_arb_resetn(dram_arb_resetn),
        .req_read_addr(req_read_addr), .req_read_len(req_read_len), .req_read_en(req_read_en),
        .req_busy(req_busy), .req_drop(req_drop), .req_read_data(req_read_data),
        .req_read_valid(req_read_valid), .mem_read_addr(mem_read_addr), .mem_read_len(mem_read_len),
        .mem_read_en(mem_read_en), .mem_read_data(mem_read_data), .mem_read_valid(mem_read_valid),
        .mem_read_busy(mem_read_busy), .stray_beat(stray_beat)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [127:0] mk(input logic [38:0] a, input logic [7:0] b);
        return {25'd0, a, 56'd0, b};
    endfunction

    task automatic check(input string nm, input logic [191:0] act, input logic [191:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic push_burst(input int o, input logic [38:0] a, input logic [7:0] l);
        exp_iss.push_back({a, l});
        for (int b = 0; b < int'(l); b++) exp_beat.push_back({2'(1) << o, mk(a, 8'(b))});
    endtask

    task automatic issue_req(input logic [1:0] m, input logic [38:0] a0, input logic [38:0] a1,
                             input logic [7:0] l0, input logic [7:0] l1, input logic [1:0] exp_drop);
        req_read_addr = {a1, a0};
        req_read_len  = {l1, l0};
        req_read_en   = m;
        @(negedge clk);
        req_read_en = 2'b00;
        check("req_drop", req_drop, exp_drop);
    endtask

    // DRAM read-master model: waits for each issue, then returns len beats.
    task automatic serve(input int nb);
        logic [38:0] a;
        logic [7:0]  l;
        int t;
        for (int k = 0; k < nb; k++) begin
            t = 0;
            while (!mem_read_en && t < 200) begin
                @(negedge clk);
                t++;
            end
            total++;
            if (!mem_read_en) begin
                bad++;
                $display("FAIL issue_wait: no mem_read_en within %0d cycles", t);
                return;
            end
            a = mem_read_addr;
            l = mem_read_len;
            mem_read_busy = 1'b1;
            for (int b = 0; b < int'(l); b++) begin
                @(negedge clk);
                mem_read_valid = 1'b1;
                mem_read_data  = mk(a, 8'(b));
            end
            @(negedge clk);
            mem_read_valid = 1'b0;
            mem_read_busy  = 1'b0;
        end
    endtask

    // Monitor: pops scoreboard entries whenever the DUT presents an issue or a beat.
    initial begin
        logic [46:0]  ei;
        logic [129:0] eb;
        forever begin
            @(negedge clk);
            if (stray_beat) stray_cnt++;
            if (mem_read_en) begin
                total++;
                if (exp_iss.size() == 0) begin
                    bad++;
                    $display("FAIL issue: unexpected burst got %0h/%0d", mem_read_addr, mem_read_len);
                end else begin
                    ei = exp_iss.pop_front();
                    total--;
                    check("issue", {mem_read_addr, mem_read_len}, ei);
                end
            end
            if (req_read_valid != 2'b00) begin
                total++;
                if (exp_beat.size() == 0) begin
                    bad++;
                    $display("FAIL beat: unexpected valid=%b data=%0h", req_read_valid, req_read_data);
                end else begin
                    eb = exp_beat.pop_front();
                    total--;
                    check("beat", {req_read_valid, req_read_data}, eb);
                end
            end
        end
    end

    initial begin
        int s0;
        int t;
        logic seen;
        dram_arb_resetn = 1'b0;
        req_read_addr   = '0;
        req_read_len    = '0;
        req_read_en     = '0;
        mem_read_data   = '0;
        mem_read_valid  = 1'b0;
        mem_read_busy   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", req_busy, 2'b00);
        check("rst_flags", {req_read_valid, req_drop, stray_beat, mem_read_en}, 0);
        check("rst_mem", {mem_read_addr, mem_read_len}, 0);
        check("rst_data", req_read_data, 0);
        dram_arb_resetn = 1'b1;
        @(negedge clk);

        // Simultaneous pair with pointer 0: req0 then req1.
        push_burst(0, 39'h2000, 8'd2);
        push_burst(1, 39'h3000, 8'd3);
        fork
            serve(2);
            begin
                issue_req(2'b11, 39'h2000, 39'h3000, 8'd2, 8'd3, 2'b00);
                check("pair_busy", req_busy, 2'b11);
            end
        join
        check("pair_done", req_busy, 2'b00);

        // Single req0, re-request while busy and len==0 request are both dropped.
        push_burst(0, 39'h1000, 8'd4);
        fork
            serve(1);
            begin
                issue_req(2'b01, 39'h1000, 39'h0, 8'd4, 8'd0, 2'b00);
                check("single_busy", req_busy, 2'b01);
                issue_req(2'b01, 39'h5555, 39'h0, 8'd3, 8'd0, 2'b01);
                issue_req(2'b10, 39'h0, 39'h7777, 8'd0, 8'd0, 2'b10);
                check("drop_busy", req_busy, 2'b01);
            end
        join
        check("single_done", req_busy, 2'b00);

        // Pointer now 1: req1 (len 1) is granted first, req0 second.
        push_burst(1, 39'h4000, 8'd1);
        push_burst(0, 39'h6000, 8'd2);
        fork
            serve(2);
            issue_req(2'b11, 39'h6000, 39'h4000, 8'd2, 8'd1, 2'b00);
        join
        check("pair2_done", req_busy, 2'b00);

        // Read master busy for 50 cycles holds off the issue.
        mem_read_busy = 1'b1;
        issue_req(2'b01, 39'h7000, 39'h0, 8'd2, 8'd0, 2'b00);
        seen = 1'b0;
        repeat (50) begin
            @(negedge clk);
            seen = seen | mem_read_en;
        end
        check("busy_hold", seen, 1'b0);
        push_burst(0, 39'h7000, 8'd2);
        mem_read_busy = 1'b0;
        @(negedge clk);
        check("issue_lat", mem_read_en, 1'b1);
        serve(1);
        check("hold_done", req_busy, 2'b00);

        // Reset after 2 of 4 beats; the remaining beats become strays.
        exp_iss.push_back({39'h8000, 8'd4});
        exp_beat.push_back({2'b01, mk(39'h8000, 8'd0)});
        exp_beat.push_back({2'b01, mk(39'h8000, 8'd1)});
        issue_req(2'b01, 39'h8000, 39'h0, 8'd4, 8'd0, 2'b00);
        t = 0;
        while (!mem_read_en && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("rst_issue", mem_read_en, 1'b1);
        mem_read_busy = 1'b1;
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            mem_read_valid = 1'b1;
            mem_read_data  = mk(39'h8000, 8'(b));
        end
        @(negedge clk);
        mem_read_valid = 1'b0;
        #1 dram_arb_resetn = 1'b0;
        #1 check("rst_async", {req_read_valid, req_busy, mem_read_en, stray_beat}, 0);
        @(negedge clk);
        dram_arb_resetn = 1'b1;
        s0 = stray_cnt;
        for (int b = 2; b < 4; b++) begin
            @(negedge clk);
            mem_read_valid = 1'b1;
            mem_read_data  = mk(39'h8000, 8'(b));
        end
        @(negedge clk);
        mem_read_valid = 1'b0;
        mem_read_busy  = 1'b0;
        @(negedge clk);
        check("stray_after_rst", stray_cnt - s0, 2);
        check("busy_after_rst", req_busy, 2'b00);

        // Lone beat in IDLE.
        s0 = stray_cnt;
        mem_read_valid = 1'b1;
        mem_read_data  = mk(39'h9999, 8'h55);
        @(negedge clk);
        mem_read_valid = 1'b0;
        @(negedge clk);
        check("stray_idle", stray_cnt - s0, 1);
        check("valid_idle", req_read_valid, 2'b00);

        repeat (3) @(negedge clk);
        check("iss_left", exp_iss.size(), 0);
        check("beat_left", exp_beat.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
